// File: rtl/weight_loader_param_1_pkg.sv
// Shared types and default dimensions for the weight BRAM loader.
package weight_loader_param_1_pkg;

    // Default image geometry: out maps per multiplier and word pairs per map.
    localparam int NUM_ONEMULT         = 2;
    localparam int NUM_ONE_PIXEL_CYCLE = 4;
    localparam int WEIGHT_ADDR_WIDTH   = 4;
    localparam int WEIGHT_WIDTH        = 16;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // Number of weight words in one complete image (two words per pair).
    function automatic int total_words(input int onemult, input int pixel_cycle);
        return onemult * pixel_cycle * 2;
    endfunction

endpackage

// File: rtl/weight_loader_param_1_if.sv
// Weight stream input plus the dual-port BRAM write side of the loader.
interface weight_loader_param_1_if #(
    parameter int WEIGHT_ADDR_WIDTH = 4,
    parameter int WEIGHT_WIDTH      = 16
);
    logic                         s_valid;
    logic                         s_ready;
    logic [WEIGHT_WIDTH-1:0]      s_data;
    logic                         wea;
    logic                         web;
    logic [WEIGHT_ADDR_WIDTH-1:0] addra;
    logic [WEIGHT_ADDR_WIDTH-1:0] addrb;
    logic [WEIGHT_WIDTH-1:0]      dina;
    logic [WEIGHT_WIDTH-1:0]      dinb;

    // Upstream producer / observer of the BRAM writes.
    modport master (
        output s_valid, s_data,
        input  s_ready, wea, web, addra, addrb, dina, dinb
    );

    // The loader itself.
    modport slave (
        input  s_valid, s_data,
        output s_ready, wea, web, addra, addrb, dina, dinb
    );
endinterface

// File: rtl/weight_loader_param_1.sv
// Weight BRAM writer: packs pairs of streamed words into one dual-port write
// (even word on port A, odd word on port B) and flags a complete image.
module weight_loader_param_1
    import weight_loader_param_1_pkg::*;
#(
    parameter int NUM_ONEMULT         = weight_loader_param_1_pkg::NUM_ONEMULT,
    parameter int NUM_ONE_PIXEL_CYCLE = weight_loader_param_1_pkg::NUM_ONE_PIXEL_CYCLE,
    parameter int WEIGHT_ADDR_WIDTH   = weight_loader_param_1_pkg::WEIGHT_ADDR_WIDTH,
    parameter int WEIGHT_WIDTH        = weight_loader_param_1_pkg::WEIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    load_done,
    weight_loader_param_1_if.slave  bus
);

    localparam int TOTAL_WORDS = total_words(NUM_ONEMULT, NUM_ONE_PIXEL_CYCLE);
    localparam int PAIR_W      = WEIGHT_ADDR_WIDTH - 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(TOTAL_WORDS / 2 - 1);

    // The whole image must fit the BRAM address space.
    generate
        if (TOTAL_WORDS > (1 << WEIGHT_ADDR_WIDTH)) begin : g_size_chk
            $error("weight_loader_param_1: TOTAL_WORDS exceeds 2**WEIGHT_ADDR_WIDTH");
        end
    endgenerate

    load_state_t                  state_r;
    load_state_t                  state_nxt_s;
    logic                         phase_r;
    logic                         phase_nxt_s;
    logic [PAIR_W-1:0]            pair_cnt_r;
    logic [PAIR_W-1:0]            pair_cnt_nxt_s;
    logic [WEIGHT_WIDTH-1:0]      hold_r;
    logic [WEIGHT_WIDTH-1:0]      hold_nxt_s;
    logic                         we_r;
    logic                         we_nxt_s;
    logic [WEIGHT_ADDR_WIDTH-1:0] addra_r;
    logic [WEIGHT_ADDR_WIDTH-1:0] addra_nxt_s;
    logic [WEIGHT_ADDR_WIDTH-1:0] addrb_r;
    logic [WEIGHT_ADDR_WIDTH-1:0] addrb_nxt_s;
    logic [WEIGHT_WIDTH-1:0]      dina_r;
    logic [WEIGHT_WIDTH-1:0]      dina_nxt_s;
    logic [WEIGHT_WIDTH-1:0]      dinb_r;
    logic [WEIGHT_WIDTH-1:0]      dinb_nxt_s;
    logic                         load_done_r;
    logic                         load_done_nxt_s;
    logic                         s_ready_s;
    logic                         xfer_s;

    // Ready purely from state: the BRAM never back-pressures the loader.
    assign s_ready_s = (state_r == ST_LOAD);
    assign xfer_s    = bus.s_valid && s_ready_s;

    // Next-state and datapath decode; every register holds unless told otherwise.
    always_comb begin
        state_nxt_s     = state_r;
        phase_nxt_s     = phase_r;
        pair_cnt_nxt_s  = pair_cnt_r;
        hold_nxt_s      = hold_r;
        we_nxt_s        = 1'b0;
        addra_nxt_s     = addra_r;
        addrb_nxt_s     = addrb_r;
        dina_nxt_s      = dina_r;
        dinb_nxt_s      = dinb_r;
        load_done_nxt_s = load_done_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Begin/restart: a fresh image always starts at pair 0, even phase.
                    state_nxt_s     = ST_LOAD;
                    phase_nxt_s     = 1'b0;
                    pair_cnt_nxt_s  = '0;
                    load_done_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = state_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    if (!phase_r) begin
                        // Even word waits in the hold register for its partner.
                        hold_nxt_s  = bus.s_data;
                        phase_nxt_s = 1'b1;
                    end else begin
                        // Odd word completes the pair: write both ports next cycle.
                        we_nxt_s       = 1'b1;
                        addra_nxt_s    = {pair_cnt_r, 1'b0};
                        addrb_nxt_s    = {pair_cnt_r, 1'b1};
                        dina_nxt_s     = hold_r;
                        dinb_nxt_s     = bus.s_data;
                        phase_nxt_s    = 1'b0;
                        pair_cnt_nxt_s = pair_cnt_r + PAIR_W'(1);
                        if (pair_cnt_r == LAST_PAIR) begin
                            // Done flag rises together with the final write strobe.
                            state_nxt_s     = ST_DONE;
                            load_done_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s     = ST_LOAD;
                        end
                    end
                end else begin
                    // Stream gap: phase and hold word are kept as long as needed.
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                phase_nxt_s     = 1'b0;
                pair_cnt_nxt_s  = '0;
                load_done_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered write-port outputs; reset discards any partial image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r     <= 1'b0;
            pair_cnt_r  <= '0;
            hold_r      <= '0;
            we_r        <= 1'b0;
            addra_r     <= '0;
            addrb_r     <= '0;
            dina_r      <= '0;
            dinb_r      <= '0;
            load_done_r <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            pair_cnt_r  <= pair_cnt_nxt_s;
            hold_r      <= hold_nxt_s;
            we_r        <= we_nxt_s;
            addra_r     <= addra_nxt_s;
            addrb_r     <= addrb_nxt_s;
            dina_r      <= dina_nxt_s;
            dinb_r      <= dinb_nxt_s;
            load_done_r <= load_done_nxt_s;
        end
    end

    // Both ports always write together, so one strobe register drives both.
    assign bus.s_ready = s_ready_s;
    assign bus.wea     = we_r;
    assign bus.web     = we_r;
    assign bus.addra   = addra_r;
    assign bus.addrb   = addrb_r;
    assign bus.dina    = dina_r;
    assign bus.dinb    = dinb_r;
    assign load_done   = load_done_r;

endmodule
